// File: rtl/mig_ui_responder_if.sv
// MIG 7-series user (app_*) interface bundle between a DDR3 read/write
// controller (master) and the memory side (slave).
//
// Handshake: a command transfers on a rising ui_clk edge where
// app_en && app_rdy; write data transfers on an edge where
// app_wdf_wren && app_wdf_rdy. The master holds app_en/app_wdf_wren and
// their payloads until the matching ready is seen, and never makes them
// depend combinationally on ready. Read data has no ready: it is valid for
// exactly one cycle when app_rd_data_valid is 1.
interface mig_ui_responder_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 28
);
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic [DATA_W-1:0]   app_wdf_data;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic                app_rdy;
    logic                app_wdf_rdy;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_rd_data_valid;
    logic                app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end
    );
endinterface

// File: rtl/mig_ui_responder.sv
// BRAM-backed stand-in for MIG 7-series + DDR3. Accepts app_* read/write
// commands, returns read data after a fixed RD_LAT cycles, fakes the
// calibration delay, optionally stalls app_rdy every RDY_PERIOD accepted
// commands, and flags protocol misuse on a sticky proto_err.
// RD_LAT must lie in 2..16; ADDR_W must exceed MEM_AW+3.
module mig_ui_responder #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 28,
    parameter int MEM_AW     = 12,
    parameter int CAL_CYCLES = 64,
    parameter int RD_LAT     = 4,
    parameter int RDY_PERIOD = 0
) (
    input  logic        ui_clk,
    input  logic        rst_n,
    mig_ui_responder_if.slave app,
    output logic        init_calib_complete,
    output logic        proto_err,
    output logic [31:0] wr_cnt,
    output logic [31:0] rd_cnt,
    output logic        dbg_state
);
    localparam int NBYTES     = DATA_W / 8;
    localparam int CAL_W      = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;
    localparam int STALL_W    = (RDY_PERIOD > 1) ? $clog2(RDY_PERIOD) : 1;
    localparam int STALL_LAST = (RDY_PERIOD > 0) ? RDY_PERIOD - 1 : 0;
    localparam logic [CAL_W-1:0]   CAL_LAST  = CAL_W'(CAL_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_END = STALL_W'(STALL_LAST);

    typedef enum logic {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t               state;
    logic [CAL_W-1:0]     cal_cnt;
    logic [STALL_W-1:0]   stall_cnt;
    logic                 rdy_q;

    logic [DATA_W-1:0]    mem [2**MEM_AW];
    logic [DATA_W-1:0]    pipe_d [RD_LAT-1];
    logic [RD_LAT-2:0]    pipe_v;
    logic [DATA_W-1:0]    rd_data_q;
    logic                 rd_valid_q;

    logic [MEM_AW-1:0]    idx;
    logic                 is_wr;
    logic                 is_rd;
    logic                 cmd_acc;
    logic                 wr_cmd_acc;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 err_now;
    logic                 unused_addr;

    assign idx         = app.app_addr[MEM_AW+2:3];
    assign unused_addr = ^app.app_addr[ADDR_W-1:MEM_AW+3];
    assign is_wr       = (app.app_cmd == 3'd0);
    assign is_rd       = (app.app_cmd == 3'd1);

    // rdy_q is 0 throughout calibration, so nothing is accepted until then.
    assign cmd_acc    = rst_n & app.app_en & rdy_q;
    assign wr_cmd_acc = cmd_acc & is_wr;
    assign wr_acc     = wr_cmd_acc & app.app_wdf_wren;
    assign rd_acc     = cmd_acc & is_rd;

    assign err_now = (wr_cmd_acc & ~app.app_wdf_wren)
                   | (app.app_wdf_wren & rdy_q & ~wr_cmd_acc)
                   | (cmd_acc & ~is_wr & ~is_rd)
                   | (init_calib_complete & (app.app_wdf_end != app.app_wdf_wren))
                   | (cmd_acc & (|app.app_addr[2:0]));

    assign app.app_rdy           = rdy_q;
    assign app.app_wdf_rdy       = rdy_q;
    assign app.app_rd_data       = rd_data_q;
    assign app.app_rd_data_valid = rd_valid_q;
    assign app.app_rd_data_end   = rd_valid_q;
    assign dbg_state             = state;

    // Calibration delay, then ready generation with periodic one-cycle stalls.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            state               <= ST_CAL;
            cal_cnt             <= '0;
            stall_cnt           <= '0;
            rdy_q               <= 1'b0;
            init_calib_complete <= 1'b0;
        end else begin
            case (state)
                ST_CAL: begin
                    if (cal_cnt == CAL_LAST) begin
                        state               <= ST_RUN;
                        init_calib_complete <= 1'b1;
                        rdy_q               <= 1'b1;
                    end else begin
                        cal_cnt <= cal_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if ((RDY_PERIOD > 0) && cmd_acc && (stall_cnt == STALL_END)) begin
                        rdy_q     <= 1'b0;
                        stall_cnt <= '0;
                    end else begin
                        rdy_q <= 1'b1;
                        if ((RDY_PERIOD > 0) && cmd_acc) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_CAL;
            endcase
        end
    end

    // BRAM port: byte-masked write, registered read, read-data shift chain.
    always_ff @(posedge ui_clk) begin
        if (wr_acc) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (!app.app_wdf_mask[b]) begin
                    mem[idx][b*8 +: 8] <= app.app_wdf_data[b*8 +: 8];
                end
            end
        end
        if (rd_acc) begin
            pipe_d[0] <= mem[idx];
        end
        for (int s = 1; s < RD_LAT - 1; s++) begin
            pipe_d[s] <= pipe_d[s-1];
        end
    end

    // Read-valid shift chain and output register; reset flushes in-flight reads.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            pipe_v     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            pipe_v[0] <= rd_acc;
            for (int s = 1; s < RD_LAT - 1; s++) begin
                pipe_v[s] <= pipe_v[s-1];
            end
            rd_valid_q <= pipe_v[RD_LAT-2];
            if (pipe_v[RD_LAT-2]) begin
                rd_data_q <= pipe_d[RD_LAT-2];
            end
        end
    end

    // Sticky protocol-error flag and accepted-command counters.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else begin
            if (err_now) begin
                proto_err <= 1'b1;
            end
            if (wr_acc) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (rd_acc) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_mig_ui_responder.sv
// Bench for mig_ui_responder: one instance without stalls (functional
// tests) and one with RDY_PERIOD=3 (backpressure). A word-indexed
// associative-array memory model predicts read data and return cycles.
module tb_mig_ui_responder;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 28;
    localparam int MEM_AW = 12;
    localparam int CAL    = 64;
    localparam int RD_LAT = 4;
    localparam int NB     = DATA_W / 8;

    // ---------------- clock / reset ----------------
    logic ui_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 ui_clk = ~ui_clk;

    int cyc = 0;
    always @(posedge ui_clk) cyc <= cyc + 1;

    mig_ui_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) a0 ();
    mig_ui_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) a3 ();

    logic        cal0, perr0, st0, cal3, perr3, st3;
    logic [31:0] wc0, rc0, wc3, rc3;

    mig_ui_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW),
        .CAL_CYCLES(CAL), .RD_LAT(RD_LAT), .RDY_PERIOD(0)) dut0 (
        .ui_clk(ui_clk), .rst_n(rst_n), .app(a0),
        .init_calib_complete(cal0), .proto_err(perr0),
        .wr_cnt(wc0), .rd_cnt(rc0), .dbg_state(st0));

    mig_ui_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW),
        .CAL_CYCLES(CAL), .RD_LAT(RD_LAT), .RDY_PERIOD(3)) dut3 (
        .ui_clk(ui_clk), .rst_n(rst_n), .app(a3),
        .init_calib_complete(cal3), .proto_err(perr3),
        .wr_cnt(wc3), .rd_cnt(rc3), .dbg_state(st3));

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] ref_mem [int];
    logic [DATA_W-1:0] exp_q [$];
    int                exp_cq [$];
    logic [DATA_W-1:0] obs_q [$];
    int                obs_cq [$];
    logic              obs_eq [$];
    int exp_wr = 0;
    int exp_rd = 0;

    // Record every read beat of the unstalled instance with its cycle number.
    always @(negedge ui_clk) begin
        if (a0.app_rd_data_valid === 1'b1) begin
            obs_q.push_back(a0.app_rd_data);
            obs_cq.push_back(cyc);
            obs_eq.push_back(a0.app_rd_data_end);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int widx(input logic [ADDR_W-1:0] addr);
        return int'((addr >> 3) % (1 << MEM_AW));
    endfunction

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wd,
                                        input logic [NB-1:0] mask);
        logic [DATA_W-1:0] w;
        int i;
        i = widx(addr);
        w = ref_mem.exists(i) ? ref_mem[i] : '0;
        for (int b = 0; b < NB; b++) begin
            if (!mask[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        end
        ref_mem[i] = w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle0();
        a0.app_en = 0; a0.app_cmd = 0; a0.app_addr = 0; a0.app_wdf_wren = 0;
        a0.app_wdf_end = 0; a0.app_wdf_data = '0; a0.app_wdf_mask = '0;
    endtask

    task automatic idle3();
        a3.app_en = 0; a3.app_cmd = 0; a3.app_addr = 0; a3.app_wdf_wren = 0;
        a3.app_wdf_end = 0; a3.app_wdf_data = '0; a3.app_wdf_mask = '0;
    endtask

    task automatic clear_sb();
        exp_q.delete(); exp_cq.delete();
        obs_q.delete(); obs_cq.delete(); obs_eq.delete();
    endtask

    // Present one command on a0 until accepted; update the model on acceptance.
    task automatic do_cmd0(input logic [2:0] cmd, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input logic [NB-1:0] mask);
        bit done;
        done = 0;
        a0.app_en = 1; a0.app_cmd = cmd; a0.app_addr = addr;
        a0.app_wdf_wren = (cmd == 3'd0); a0.app_wdf_end = (cmd == 3'd0);
        a0.app_wdf_data = wd; a0.app_wdf_mask = mask;
        for (int t = 0; t < 8 && !done; t++) begin
            @(negedge ui_clk);
            if (a0.app_rdy === 1'b1) begin
                done = 1;
                if (cmd == 3'd0) begin
                    model_write(addr, wd, mask);
                    exp_wr++;
                end else if (cmd == 3'd1) begin
                    exp_q.push_back(ref_mem[widx(addr)]);
                    exp_cq.push_back(cyc + RD_LAT);
                    exp_rd++;
                end
            end
            @(posedge ui_clk); #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL cmd_accept cmd %0d addr %h got no app_rdy exp accept", cmd, addr);
        end
    endtask

    // Idle the bus and give outstanding reads (and any stray beats) time to land.
    task automatic wait_reads();
        idle0();
        for (int t = 0; t < 64 && obs_q.size() < exp_q.size(); t++) @(negedge ui_clk);
        repeat (RD_LAT + 2) @(negedge ui_clk);
        @(posedge ui_clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int rel;
        bit found;
        bit rdy_early;
        logic [DATA_W-1:0] cal_word;
        cal_word = rand128();
        idle3();
        a0.app_en = 1; a0.app_cmd = 0; a0.app_addr = 0; a0.app_wdf_wren = 1;
        a0.app_wdf_end = 1; a0.app_wdf_mask = '0; a0.app_wdf_data = cal_word;
        rst_n = 0;
        repeat (3) @(posedge ui_clk);
        @(negedge ui_clk);
        checks++;
        if ({a0.app_rdy, a0.app_wdf_rdy, a0.app_rd_data_valid, a0.app_rd_data_end, cal0, perr0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000",
                {a0.app_rdy, a0.app_wdf_rdy, a0.app_rd_data_valid, a0.app_rd_data_end, cal0, perr0});
        end
        checks++;
        if (wc0 !== 32'd0 || rc0 !== 32'd0 || a0.app_rd_data !== '0) begin
            errors++;
            $display("FAIL reset_counters got wr %0d rd %0d data %h exp 0", wc0, rc0, a0.app_rd_data);
        end
        @(posedge ui_clk); #1;
        rst_n = 1;
        rel = cyc;
        found = 0;
        rdy_early = 0;
        for (int t = 0; t < CAL + 8 && !found; t++) begin
            @(negedge ui_clk);
            if (cal0 === 1'b1) found = 1;
            else if (a0.app_rdy !== 1'b0 || a0.app_wdf_rdy !== 1'b0) rdy_early = 1;
        end
        checks++;
        if (!found || (cyc - rel) != CAL) begin
            errors++;
            $display("FAIL calib_latency got found %0d after %0d cycles exp %0d", found, cyc - rel, CAL);
        end
        checks++;
        if (rdy_early) begin
            errors++;
            $display("FAIL calib_rdy_low got ready before calibration exp 0");
        end
        checks++;
        if (a0.app_rdy !== 1'b1 || a0.app_wdf_rdy !== 1'b1 || wc0 !== 32'd0 || perr0 !== 1'b0) begin
            errors++;
            $display("FAIL calib_done_state got rdy %b wdf_rdy %b wr %0d perr %b exp 1 1 0 0",
                a0.app_rdy, a0.app_wdf_rdy, wc0, perr0);
        end
        @(posedge ui_clk); #1;
        idle0();
        model_write('0, cal_word, '0);
        exp_wr = 1;
        exp_rd = 0;
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] d;
        clear_sb();
        d = rand128();
        d[7:0] = 8'hA5;
        do_cmd0(3'd0, 28'h10, d, '0);
        do_cmd0(3'd1, 28'h10, '0, '0);
        wait_reads();
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL wr_rd_count got %0d beats exp 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== d || obs_cq[0] != exp_cq[0] || obs_eq[0] !== 1'b1) begin
                errors++;
                $display("FAIL wr_rd_beat got %h cyc %0d end %b exp %h cyc %0d end 1",
                    obs_q[0], obs_cq[0], obs_eq[0], d, exp_cq[0]);
            end
        end
        checks++;
        if (wc0 !== 32'(exp_wr) || rc0 !== 32'(exp_rd)) begin
            errors++;
            $display("FAIL wr_rd_counters got wr %0d rd %0d exp %0d %0d", wc0, rc0, exp_wr, exp_rd);
        end
    endtask

    task automatic test_burst();
        clear_sb();
        for (int i = 0; i < 16; i++) do_cmd0(3'd0, ADDR_W'(i * 8), rand128(), '0);
        for (int i = 0; i < 16; i++) do_cmd0(3'd1, ADDR_W'(i * 8), '0, '0);
        wait_reads();
        checks++;
        if (obs_q.size() != 16) begin
            errors++;
            $display("FAIL burst_count got %0d beats exp 16", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_cq[i] != exp_cq[i] || obs_eq[i] !== 1'b1) begin
                errors++;
                $display("FAIL burst_beat%0d got %h cyc %0d end %b exp %h cyc %0d",
                    i, obs_q[i], obs_cq[i], obs_eq[i], exp_q[i], exp_cq[i]);
            end
        end
        if (obs_q.size() == 16) begin
            checks++;
            if (obs_cq[15] - obs_cq[0] != 15) begin
                errors++;
                $display("FAIL burst_contiguous got span %0d exp 15", obs_cq[15] - obs_cq[0]);
            end
        end
    endtask

    task automatic test_masked();
        logic [DATA_W-1:0] want;
        want = {{64{1'b0}}, {64{1'b1}}};
        clear_sb();
        do_cmd0(3'd0, 28'd160, {DATA_W{1'b1}}, '0);
        do_cmd0(3'd0, 28'd160, '0, 16'h00FF);
        do_cmd0(3'd1, 28'd160, '0, '0);
        wait_reads();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== want || obs_cq[0] != exp_cq[0]) begin
            errors++;
            $display("FAIL masked_write got %0d beats data %h exp 1 beat %h",
                obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, want);
        end
    endtask

    task automatic test_alias();
        logic [DATA_W-1:0] d;
        clear_sb();
        d = rand128();
        do_cmd0(3'd0, 28'd0, d, '0);
        do_cmd0(3'd1, ADDR_W'(1 << (MEM_AW + 3)), '0, '0);
        wait_reads();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== d) begin
            errors++;
            $display("FAIL alias_read got %0d beats data %h exp 1 beat %h",
                obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, d);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] addr;
        clear_sb();
        for (int n = 0; n < 48; n++) begin
            addr = (ADDR_W'($urandom_range(0, 3)) << (MEM_AW + 3)) | (ADDR_W'($urandom_range(0, 15)) << 3);
            if ($urandom_range(0, 1) == 1) do_cmd0(3'd0, addr, rand128(), NB'($urandom()));
            else do_cmd0(3'd1, addr, '0, '0);
            if ($urandom_range(0, 3) == 0) begin
                idle0();
                repeat ($urandom_range(1, 3)) @(posedge ui_clk);
                #1;
            end
        end
        wait_reads();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d beats exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_cq[i] != exp_cq[i]) begin
                errors++;
                $display("FAIL random_beat%0d got %h cyc %0d exp %h cyc %0d",
                    i, obs_q[i], obs_cq[i], exp_q[i], exp_cq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_pat;
        logic [11:0] got_pat;
        int sent;
        int k;
        bit wdf_mis;
        exp_pat = '0;
        k = 0;
        for (int i = 1; i <= 9; i++) begin
            exp_pat[11 - k] = 1'b1;
            k++;
            if (i % 3 == 0) k++;
        end
        got_pat = '0;
        sent = 0;
        wdf_mis = 0;
        for (int t = 0; t < 12; t++) begin
            if (sent < 9) begin
                a3.app_en = 1; a3.app_cmd = 0; a3.app_addr = ADDR_W'(sent * 8);
                a3.app_wdf_wren = 1; a3.app_wdf_end = 1;
                a3.app_wdf_data = rand128(); a3.app_wdf_mask = '0;
            end else begin
                idle3();
            end
            @(negedge ui_clk);
            got_pat[11 - t] = a3.app_rdy;
            if (a3.app_wdf_rdy !== a3.app_rdy) wdf_mis = 1;
            if (sent < 9 && a3.app_rdy === 1'b1) sent++;
            @(posedge ui_clk); #1;
        end
        idle3();
        @(negedge ui_clk);
        checks++;
        if (got_pat !== exp_pat) begin
            errors++;
            $display("FAIL bp_rdy_pattern got %b exp %b", got_pat, exp_pat);
        end
        checks++;
        if (wdf_mis) begin
            errors++;
            $display("FAIL bp_wdf_rdy got differs from app_rdy exp equal");
        end
        checks++;
        if (sent != 9 || wc3 !== 32'd9 || perr3 !== 1'b0) begin
            errors++;
            $display("FAIL bp_complete got sent %0d wr %0d perr %b exp 9 9 0", sent, wc3, perr3);
        end
        @(posedge ui_clk); #1;
    endtask

    task automatic test_errors();
        clear_sb();
        checks++;
        if (perr0 !== 1'b0) begin
            errors++;
            $display("FAIL err_clean got proto_err %b exp 0", perr0);
        end
        do_cmd0(3'd2, 28'h40, '0, '0);
        idle0();
        @(negedge ui_clk);
        checks++;
        if (perr0 !== 1'b1) begin
            errors++;
            $display("FAIL err_illegal_cmd got proto_err %b exp 1", perr0);
        end
        repeat (10) @(negedge ui_clk);
        checks++;
        if (perr0 !== 1'b1 || obs_q.size() != 0 || wc0 !== 32'(exp_wr) || rc0 !== 32'(exp_rd)) begin
            errors++;
            $display("FAIL err_sticky got perr %b beats %0d wr %0d rd %0d exp 1 0 %0d %0d",
                perr0, obs_q.size(), wc0, rc0, exp_wr, exp_rd);
        end
        @(posedge ui_clk); #1;
    endtask

    task automatic test_reset_flush();
        bit found;
        clear_sb();
        do_cmd0(3'd1, 28'h18, '0, '0);
        rst_n = 0;
        idle0();
        exp_q.delete();
        exp_cq.delete();
        repeat (2) @(posedge ui_clk);
        #1;
        rst_n = 1;
        @(negedge ui_clk);
        checks++;
        if (a0.app_rd_data !== '0 || perr0 !== 1'b0 || wc0 !== 32'd0 || rc0 !== 32'd0 || cal0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_reset_state got data %h perr %b wr %0d rd %0d cal %b exp 0",
                a0.app_rd_data, perr0, wc0, rc0, cal0);
        end
        found = 0;
        for (int t = 0; t < CAL + 8 && !found; t++) begin
            @(negedge ui_clk);
            if (cal0 === 1'b1) found = 1;
        end
        checks++;
        if (!found || obs_q.size() != 0) begin
            errors++;
            $display("FAIL flush_no_valid got cal %0d beats %0d exp 1 0", found, obs_q.size());
        end
        @(posedge ui_clk); #1;
        exp_wr = 0;
        exp_rd = 0;
        for (int i = 0; i < 16; i++) do_cmd0(3'd1, ADDR_W'(i * 8), '0, '0);
        wait_reads();
        checks++;
        if (obs_q.size() != 16 || rc0 !== 32'd16) begin
            errors++;
            $display("FAIL flush_readback_count got %0d beats rd %0d exp 16 16", obs_q.size(), rc0);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_cq[i] != exp_cq[i]) begin
                errors++;
                $display("FAIL flush_readback%0d got %h cyc %0d exp %h cyc %0d",
                    i, obs_q[i], obs_cq[i], exp_q[i], exp_cq[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [DATA_W-1:0] d;
        clear_sb();
        d = rand128();
        checks++;
        if (perr0 !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pre got proto_err %b exp 0", perr0);
        end
        do_cmd0(3'd0, 28'h43, d, '0);
        do_cmd0(3'd1, 28'h40, '0, '0);
        wait_reads();
        checks++;
        if (perr0 !== 1'b1 || obs_q.size() != 1 || obs_q[0] !== d) begin
            errors++;
            $display("FAIL misalign_exec got perr %b beats %0d data %h exp 1 1 %h",
                perr0, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, d);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle0();
        idle3();
        test_reset();
        test_write_read();
        test_burst();
        test_masked();
        test_alias();
        test_random();
        test_backpressure();
        test_errors();
        test_reset_flush();
        test_misaligned();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
